// File: rtl/mcu_if.sv
// AXI-lite style data-memory bus: the controller masters addresses, valids and write data;
// the memory side returns readies, read data and write responses.
interface mcu_axi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic              wvalid;
   logic              wready;
   logic              bvalid;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (
      output awaddr, awvalid, wdata, wvalid, araddr, arvalid,
      input  awready, wready, bvalid, arready, rdata, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, araddr, arvalid,
      output awready, wready, bvalid, arready, rdata, rvalid
   );
endinterface

// File: rtl/mcu.sv
// Round-robin data-memory controller: THREADS_PER_WARP+1 LSU consumers share one AXI-lite master.
// Zero-wait memory gives request->ready in 2 cycles; one transaction in flight, others are held off.
module mcu #(
   parameter int THREADS_PER_WARP = 16,
   parameter int ADDR_W           = 32,
   parameter int DATA_W           = 32,
   localparam int N               = THREADS_PER_WARP + 1,
   localparam int IDX_W           = $clog2(N)
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      mcu_is_busy_o,
   input  logic [N-1:0]              consumer_read_valid_i,
   input  logic [N-1:0][ADDR_W-1:0]  consumer_read_address_i,
   output logic [N-1:0]              consumer_read_ready_o,
   output logic [N-1:0][DATA_W-1:0]  consumer_read_data_o,
   input  logic [N-1:0]              consumer_write_valid_i,
   input  logic [N-1:0][ADDR_W-1:0]  consumer_write_address_i,
   input  logic [N-1:0][DATA_W-1:0]  consumer_write_data_i,
   output logic [N-1:0]              consumer_write_ready_o,
   mcu_axi_if.master                 m_axi
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RD_ACK, WR_ACK
   } state_e;

   state_e                  state_q;
   logic [IDX_W-1:0]        rr_q;
   logic [IDX_W-1:0]        g_q;
   logic                    busy_q;
   logic                    arvalid_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic [ADDR_W-1:0]       araddr_q;
   logic [ADDR_W-1:0]       awaddr_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [N-1:0]            rd_rdy_q;
   logic [N-1:0]            wr_rdy_q;
   logic [N-1:0][DATA_W-1:0] rd_data_q;

   logic [N-1:0]            req;
   logic                    grant_vld;
   logic [IDX_W-1:0]        grant_idx;
   logic [IDX_W:0]          cand;
   logic [IDX_W-1:0]        rr_d;

   assign req = consumer_read_valid_i | consumer_write_valid_i;

   // First requester at or after rr, wrapping modulo N.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) begin
            cand = cand - (IDX_W+1)'(N);
         end
         if (!grant_vld && req[cand[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

   assign rr_d = (g_q == IDX_W'(N-1)) ? '0 : g_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         g_q       <= '0;
         busy_q    <= 1'b0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         rd_rdy_q  <= '0;
         wr_rdy_q  <= '0;
         rd_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  g_q    <= grant_idx;
                  busy_q <= 1'b1;
                  // Read wins over write from the same consumer.
                  if (consumer_read_valid_i[grant_idx]) begin
                     araddr_q  <= consumer_read_address_i[grant_idx];
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end else begin
                     awaddr_q  <= consumer_write_address_i[grant_idx];
                     wdata_q   <= consumer_write_data_i[grant_idx];
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  if (m_axi.rvalid) begin
                     rd_data_q[g_q] <= m_axi.rdata;
                     rd_rdy_q[g_q]  <= 1'b1;
                     state_q        <= RD_ACK;
                  end else begin
                     state_q <= RD_DATA;
                  end
               end
            end
            RD_DATA: begin
               if (m_axi.rvalid) begin
                  rd_data_q[g_q] <= m_axi.rdata;
                  rd_rdy_q[g_q]  <= 1'b1;
                  state_q        <= RD_ACK;
               end
            end
            WR_ADDR: begin
               if (m_axi.awready && m_axi.wready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b0;
                  if (m_axi.bvalid) begin
                     wr_rdy_q[g_q] <= 1'b1;
                     state_q       <= WR_ACK;
                  end else begin
                     state_q <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (m_axi.bvalid) begin
                  wr_rdy_q[g_q] <= 1'b1;
                  state_q       <= WR_ACK;
               end
            end
            RD_ACK: begin
               if (!consumer_read_valid_i[g_q]) begin
                  rd_rdy_q[g_q] <= 1'b0;
                  rr_q          <= rr_d;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            WR_ACK: begin
               if (!consumer_write_valid_i[g_q]) begin
                  wr_rdy_q[g_q] <= 1'b0;
                  rr_q          <= rr_d;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mcu_is_busy_o          = busy_q;
   assign consumer_read_ready_o  = rd_rdy_q;
   assign consumer_write_ready_o = wr_rdy_q;
   assign consumer_read_data_o   = rd_data_q;
   assign m_axi.arvalid          = arvalid_q;
   assign m_axi.araddr           = araddr_q;
   assign m_axi.awvalid          = awvalid_q;
   assign m_axi.awaddr           = awaddr_q;
   assign m_axi.wvalid           = wvalid_q;
   assign m_axi.wdata            = wdata_q;

   a_one_ready: assert property (@(posedge clk) disable iff (reset)
      $onehot0({rd_rdy_q, wr_rdy_q}));
   a_one_channel: assert property (@(posedge clk) disable iff (reset)
      !(arvalid_q && (awvalid_q || wvalid_q)));

endmodule

// File: tb/tb_mcu.sv
// Scoreboard bench for mcu: a latency-programmable memory responder plus per-scenario tasks.
module tb_mcu;
   localparam int N = 17;

   typedef struct {
      int          idx;
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic                 clk;
   logic                 reset;
   logic                 busy;
   logic [N-1:0]         rd_vld;
   logic [N-1:0][31:0]   rd_addr;
   logic [N-1:0]         rd_rdy;
   logic [N-1:0][31:0]   rd_data;
   logic [N-1:0]         wr_vld;
   logic [N-1:0][31:0]   wr_addr;
   logic [N-1:0][31:0]   wr_data;
   logic [N-1:0]         wr_rdy;

   mcu_axi_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   mcu #(.THREADS_PER_WARP(16), .ADDR_W(32), .DATA_W(32)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .mcu_is_busy_o            (busy),
      .consumer_read_valid_i    (rd_vld),
      .consumer_read_address_i  (rd_addr),
      .consumer_read_ready_o    (rd_rdy),
      .consumer_read_data_o     (rd_data),
      .consumer_write_valid_i   (wr_vld),
      .consumer_write_address_i (wr_addr),
      .consumer_write_data_i    (wr_data),
      .consumer_write_ready_o   (wr_rdy),
      .m_axi                    (axi)
   );

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb[$];
   logic [31:0] mem [logic [31:0]];

   int ar_lat = 0, r_lat = 0, aw_lat = 0, b_lat = 0;
   bit rd_act = 0, wr_act = 0;
   int rcyc = 0, wcyc = 0;
   logic [31:0] raddr_l, waddr_l, wdata_l;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory responder: offsets count cycles from the first cycle a valid is seen.
   initial begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
      forever begin
         @(negedge clk);
         axi.arready = 1'b0; axi.rvalid = 1'b0;
         axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
         if (reset) begin
            rd_act = 0;
            wr_act = 0;
         end else begin
            if (rd_act) rcyc++;
            else if (axi.arvalid) begin rd_act = 1; rcyc = 0; raddr_l = axi.araddr; end
            if (rd_act) begin
               if (rcyc == ar_lat) axi.arready = 1'b1;
               if (rcyc == r_lat) begin axi.rvalid = 1'b1; axi.rdata = mem_rd(raddr_l); rd_act = 0; end
            end
            if (wr_act) wcyc++;
            else if (axi.awvalid) begin wr_act = 1; wcyc = 0; waddr_l = axi.awaddr; wdata_l = axi.wdata; end
            if (wr_act) begin
               if (wcyc == aw_lat) begin axi.awready = 1'b1; axi.wready = 1'b1; mem[waddr_l] = wdata_l; end
               if (wcyc == b_lat) begin axi.bvalid = 1'b1; wr_act = 0; end
            end
         end
      end
   end

   task automatic req_rd(input int idx, input logic [31:0] a);
      rd_addr[idx] = a;
      rd_vld[idx]  = 1'b1;
      sb.push_back('{idx, 1'b1, a, mem_rd(a)});
   endtask

   task automatic req_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
      wr_addr[idx] = a;
      wr_data[idx] = d;
      wr_vld[idx]  = 1'b1;
      sb.push_back('{idx, 1'b0, a, d});
   endtask

   // Completes every queued transaction as the consumer side, checking service order and data.
   task automatic serve(input int budget);
      int cyc;
      exp_t e;
      cyc = 0;
      while (sb.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (!$onehot0({rd_rdy, wr_rdy})) begin
            n_fail++;
            $display("FAIL one_ready: rd_rdy=%h wr_rdy=%h, required at most one bit", rd_rdy, wr_rdy);
         end
         for (int i = 0; i < N; i++) begin
            if (rd_rdy[i] || wr_rdy[i]) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_ready: consumer %0d ready, required no pending transaction", i);
               end else begin
                  e = sb.pop_front();
                  n_checks++;
                  if (i !== e.idx || rd_rdy[i] !== e.is_rd) begin
                     n_fail++;
                     $display("FAIL order: served consumer %0d read=%0d, required consumer %0d read=%0d",
                              i, rd_rdy[i], e.idx, e.is_rd);
                  end else if (e.is_rd && rd_data[i] !== e.data) begin
                     n_fail++;
                     $display("FAIL rd_data[%0d]: got %h, required %h", i, rd_data[i], e.data);
                  end else if (!e.is_rd && mem_rd(e.addr) !== e.data) begin
                     n_fail++;
                     $display("FAIL wr_data[%0d]: memory %h holds %h, required %h", i, e.addr, mem_rd(e.addr), e.data);
                  end
               end
               if (rd_rdy[i]) rd_vld[i] = 1'b0;
               else           wr_vld[i] = 1'b0;
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL serve_timeout: %0d transactions outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rd_rdy !== '0 || wr_rdy !== '0 || rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_consumer: busy=%b rd_rdy=%h wr_rdy=%h, required all 0", busy, rd_rdy, wr_rdy);
      end
      n_checks++;
      if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000 || axi.araddr !== '0 || axi.awaddr !== '0 || axi.wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_axi: ar/aw/w valid=%b%b%b, required 000 with zero buses", axi.arvalid, axi.awvalid, axi.wvalid);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_busy: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_single_read();
      exp_t e;
      mem[32'h40] = 32'hDEADBEEF;
      ar_lat = 0; r_lat = 0;
      @(negedge clk);
      req_rd(3, 32'h40);
      @(negedge clk);
      n_checks++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h40 || busy !== 1'b1 || rd_rdy !== '0) begin
         n_fail++;
         $display("FAIL rd_cycle1: arvalid=%b araddr=%h busy=%b, required 1 00000040 1", axi.arvalid, axi.araddr, busy);
      end
      @(negedge clk);
      n_checks++;
      if (rd_rdy !== 17'h00008 || axi.arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_cycle2: rd_rdy=%h arvalid=%b, required 00008 0", rd_rdy, axi.arvalid);
      end
      e = sb.pop_front();
      n_checks++;
      if (rd_data[3] !== e.data) begin
         n_fail++;
         $display("FAIL rd_data3: got %h, required %h", rd_data[3], e.data);
      end
      rd_vld[3] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rd_rdy !== '0 || busy !== 1'b0 || rd_data[3] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_release: rd_rdy=%h busy=%b data=%h, required 0 0 deadbeef", rd_rdy, busy, rd_data[3]);
      end
   endtask

   task automatic test_single_write();
      exp_t e;
      aw_lat = 0; b_lat = 1;
      @(negedge clk);
      req_wr(16, 32'h10, 32'h1234);
      @(negedge clk);
      n_checks++;
      if ({axi.awvalid, axi.wvalid} !== 2'b11 || axi.awaddr !== 32'h10 || axi.wdata !== 32'h1234 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_cycle1: aw/wvalid=%b%b awaddr=%h wdata=%h busy=%b, required 11 10 1234 1",
                  axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, busy);
      end
      @(negedge clk);
      n_checks++;
      if ({axi.awvalid, axi.wvalid} !== 2'b00 || wr_rdy !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_resp_wait: aw/wvalid=%b%b wr_rdy=%h busy=%b, required 00 0 1", axi.awvalid, axi.wvalid, wr_rdy, busy);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (wr_rdy !== 17'h10000 || busy !== 1'b1 || mem_rd(e.addr) !== e.data) begin
         n_fail++;
         $display("FAIL wr_ack: wr_rdy=%h busy=%b mem=%h, required 10000 1 %h", wr_rdy, busy, mem_rd(e.addr), e.data);
      end
      wr_vld[16] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_rdy !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_release: wr_rdy=%h busy=%b, required 0 0", wr_rdy, busy);
      end
      b_lat = 0;
   endtask

   task automatic test_contention();
      @(negedge clk);
      req_rd(0, 32'h100);
      req_rd(16, 32'h104);
      serve(40);
      @(negedge clk);
      req_rd(0, 32'h108);
      serve(20);
      @(negedge clk);
      rd_addr[0] = 32'h10C; rd_vld[0] = 1'b1;
      req_rd(5, 32'h110);
      req_wr(12, 32'h114, 32'hCAFE0012);
      sb.push_back('{0, 1'b1, 32'h10C, mem_rd(32'h10C)});
      serve(60);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_wr(1, 32'h204, 32'h0000_1111);
      req_rd(2, 32'h208);
      req_wr(9, 32'h224, 32'h0000_9999);
      req_rd(14, 32'h238);
      serve(80);
   endtask

   task automatic test_slow_memory();
      exp_t e;
      ar_lat = 0; r_lat = 4;
      @(negedge clk);
      req_rd(5, 32'h80);
      @(negedge clk);
      n_checks++;
      if (axi.arvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL slow_arvalid: arvalid=%b, required 1", axi.arvalid);
      end
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (axi.arvalid !== 1'b0 || rd_rdy !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_wait c%0d: arvalid=%b rd_rdy=%h busy=%b, required 0 0 1", c, axi.arvalid, rd_rdy, busy);
         end
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (rd_rdy !== 17'h00020 || rd_data[5] !== e.data) begin
         n_fail++;
         $display("FAIL slow_ack: rd_rdy=%h data=%h, required 00020 %h", rd_rdy, rd_data[5], e.data);
      end
      rd_vld[5] = 1'b0;
      r_lat = 0;
   endtask

   task automatic test_rd_wr_same();
      @(negedge clk);
      req_rd(8, 32'h300);
      req_wr(8, 32'h304, 32'h0000_8888);
      serve(40);
   endtask

   task automatic test_drop_valid();
      exp_t e;
      r_lat = 3;
      @(negedge clk);
      req_rd(4, 32'h400);
      @(negedge clk);
      @(negedge clk);
      rd_vld[4] = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (rd_rdy !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_wait: rd_rdy=%h busy=%b, required 0 1", rd_rdy, busy);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (rd_rdy !== 17'h00010 || rd_data[4] !== e.data) begin
         n_fail++;
         $display("FAIL drop_ack: rd_rdy=%h data=%h, required 00010 %h", rd_rdy, rd_data[4], e.data);
      end
      @(negedge clk);
      n_checks++;
      if (rd_rdy !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_exit: rd_rdy=%h busy=%b, required 0 0", rd_rdy, busy);
      end
      r_lat = 0;
   endtask

   task automatic test_reset_mid();
      r_lat = 8;
      @(negedge clk);
      rd_addr[2] = 32'h500; rd_vld[2] = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (axi.arvalid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rd_data: arvalid=%b busy=%b, required 0 1", axi.arvalid, busy);
      end
      @(negedge clk);
      reset  = 1'b1;
      rd_vld = '0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rd_rdy !== '0 || wr_rdy !== '0 || rd_data !== '0 ||
          {axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000 || axi.araddr !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b rd_rdy=%h arvalid=%b araddr=%h, required all 0", busy, rd_rdy, axi.arvalid, axi.araddr);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      r_lat = 0;
      @(negedge clk);
      req_rd(3, 32'h504);
      req_wr(16, 32'h508, 32'h0000_ABCD);
      serve(40);
   endtask

   initial begin
      reset   = 1'b1;
      rd_vld  = '0; rd_addr = '0;
      wr_vld  = '0; wr_addr = '0; wr_data = '0;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_back_to_back();
      test_slow_memory();
      test_rd_wr_same();
      test_drop_valid();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
